// File: rtl/ifu.sv
// Instruction fetch unit: drives a req/gnt/rvalid instruction memory, buffers the
// returned words and presents {inst, inst_pc} to the decoder. Define IFU_MISALIGN_CHECK_EN
// to flag misaligned redirects with a sticky fetch_err instead of silently aligning them.
module ifu #(
    parameter int                   CPU_WIDTH  = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC   = '0,
    parameter int                   FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    input  logic                 redirect,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 inst_valid,
    output logic [CPU_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0] inst_pc,
    input  logic                 inst_ready,
    output logic                 fetch_err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [CPU_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CPU_WIDTH-1:0] head_pc_q, head_pc_d;
    logic [CPU_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [CPU_WIDTH-1:0] fifo_d [FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]        live_cnt_q, live_cnt_d;
    logic [CW-1:0]        drop_cnt_q, drop_cnt_d;
    logic                 err_q, err_d;

    logic [CPU_WIDTH-1:0] redir_pc;
    logic                 misalign;
    logic                 halted;
    logic [CW+1:0]        in_use;
    logic                 gnt_fire, push, pop;

`ifdef IFU_MISALIGN_CHECK_EN
    assign redir_pc  = redirect_pc;
    assign misalign  = |redirect_pc[1:0];
    assign halted    = err_q;
    assign fetch_err = err_q && !rst;
`else
    logic unused_lowbits;
    assign unused_lowbits = ^{redirect_pc[1:0], err_q};
    assign redir_pc  = {redirect_pc[CPU_WIDTH-1:2], 2'b00};
    assign misalign  = 1'b0;
    assign halted    = 1'b0;
    assign fetch_err = 1'b0;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Buffered plus in-flight words (kept or dropped) never exceed the FIFO size,
    // so every response that is kept is guaranteed a slot.
    assign in_use = (CW+2)'(fifo_cnt_q) + (CW+2)'(live_cnt_q) + (CW+2)'(drop_cnt_q);

    assign imem_req   = !rst && !redirect && !halted && (in_use < (CW+2)'(FIFO_DEPTH));
    assign imem_addr  = fetch_pc_q;
    assign inst_valid = !rst && !redirect && (fifo_cnt_q != '0);
    assign inst       = fifo_q[rd_ptr_q];
    assign inst_pc    = head_pc_q;

    assign gnt_fire = imem_req && imem_gnt;
    assign push     = imem_rvalid && (drop_cnt_q == '0);
    assign pop      = inst_valid && inst_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        live_cnt_d = live_cnt_q + CW'(gnt_fire) - CW'(push);
        drop_cnt_d = drop_cnt_q;
        err_d      = err_q;

        if (gnt_fire) fetch_pc_d = fetch_pc_q + CPU_WIDTH'(4);
        if (imem_rvalid && !push) drop_cnt_d = drop_cnt_q - 1'b1;
        if (push) begin
            fifo_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            head_pc_d = head_pc_q + CPU_WIDTH'(4);
            rd_ptr_d  = ptr_inc(rd_ptr_q);
        end

        // A response landing in the redirect cycle belongs to the old stream.
        if (redirect) begin
            fetch_pc_d = redir_pc;
            head_pc_d  = redir_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fifo_cnt_d = '0;
            drop_cnt_d = drop_cnt_q + live_cnt_q - CW'(imem_rvalid);
            live_cnt_d = '0;
            err_d      = misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            live_cnt_q <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            live_cnt_q <= live_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule
